// File: rtl/div_clk_monitor.sv
// Fast-domain receiver for the ripple-divided loop clock: synchronises it, ticks on
// each rising edge, measures its period and reports lock / fault status.
module div_clk_monitor #(
    parameter int EXP_PERIOD = 8,
    parameter int TOL        = 1,
    parameter int LOCK_CNT   = 4,
    parameter int CNT_W      = 8,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clk_div_in,
    input  logic             en,
    input  logic             clr_err,
    output logic             tick,
    output logic             locked,
    output logic             fault,
    output logic [CNT_W-1:0] period,
    output logic [ERR_W-1:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, FIRST, TRACK, LOCKED} state_t;

    localparam int               GOOD_W      = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] WIN_LO      = CNT_W'(EXP_PERIOD - TOL);
    localparam logic [CNT_W-1:0] WIN_HI      = CNT_W'(EXP_PERIOD + TOL);
    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(EXP_PERIOD + TOL + 1);
    localparam logic [GOOD_W-1:0] LAST_GOOD  = GOOD_W'(LOCK_CNT - 1);

    logic              s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic              tick_q, tick_d;
    logic              fault_q, fault_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    state_t            state_q, state_d;
    logic [GOOD_W-1:0] good_q, good_d;

    logic rise, in_win, timeout, err_event;

    assign rise    = s2_q & ~s3_q;
    assign in_win  = (cnt_q >= WIN_LO) && (cnt_q <= WIN_HI);
    assign timeout = ~rise && (cnt_q == TIMEOUT_CNT);

    // Datapath next-state: synchroniser, period counter, outputs.
    // NOTE: every always_comb output gets a value on every path; a missing branch would infer a latch.
    always_comb begin
        s1_d     = clk_div_in;
        s2_d     = s1_q;
        s3_d     = s2_q;
        cnt_d    = rise ? CNT_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + CNT_W'(1));
        period_d = (rise && en) ? cnt_q : period_q;
        tick_d   = rise & en;
        fault_d  = err_event;
        if (clr_err)
            err_cnt_d = '0;
        else if (err_event && !(&err_cnt_q))
            err_cnt_d = err_cnt_q + ERR_W'(1);
        else
            err_cnt_d = err_cnt_q;
    end

    // Lock FSM; FIRST only re-arms measurement, so edges seen there are never judged.
    always_comb begin
        state_d   = state_q;
        good_d    = good_q;
        err_event = 1'b0;
        if (!en) begin
            state_d = IDLE;
            good_d  = '0;
        end else begin
            unique case (state_q)
                IDLE:  state_d = FIRST;
                FIRST: if (rise) begin
                    state_d = TRACK;
                    good_d  = '0;
                end
                TRACK: begin
                    if (rise && in_win) begin
                        if (good_q == LAST_GOOD) begin
                            state_d = LOCKED;
                            good_d  = '0;
                        end else begin
                            good_d = good_q + GOOD_W'(1);
                        end
                    end else if (rise) begin
                        err_event = 1'b1;
                        good_d    = '0;
                    end else if (timeout) begin
                        err_event = 1'b1;
                        state_d   = FIRST;
                        good_d    = '0;
                    end
                end
                LOCKED: begin
                    if (rise && !in_win) begin
                        err_event = 1'b1;
                        state_d   = TRACK;
                        good_d    = '0;
                    end else if (timeout) begin
                        err_event = 1'b1;
                        state_d   = FIRST;
                        good_d    = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s3_q      <= 1'b0;
            cnt_q     <= '0;
            period_q  <= '0;
            tick_q    <= 1'b0;
            fault_q   <= 1'b0;
            err_cnt_q <= '0;
            state_q   <= IDLE;
            good_q    <= '0;
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            s3_q      <= s3_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            tick_q    <= tick_d;
            fault_q   <= fault_d;
            err_cnt_q <= err_cnt_d;
            state_q   <= state_d;
            good_q    <= good_d;
        end
    end

    assign tick    = tick_q;
    assign fault   = fault_q;
    assign period  = period_q;
    assign err_cnt = err_cnt_q;
    assign locked  = (state_q == LOCKED);

endmodule

// File: tb/tb_div_clk_monitor.sv
// Directed bench for div_clk_monitor: lock, period errors, timeout, saturation,
// clear priority, asynchronous reset and enable gating.
module tb_div_clk_monitor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       clk_div_in;
    logic       en;
    logic       clr_err;
    logic       tick;
    logic       locked;
    logic       fault;
    logic [7:0] period;
    logic [7:0] err_cnt;

    int n_cmp   = 0;
    int n_fail  = 0;
    int n_tick  = 0;
    int n_fault = 0;
    int snap_tick, snap_fault;

    div_clk_monitor #(
        .EXP_PERIOD(8), .TOL(1), .LOCK_CNT(4), .CNT_W(8), .ERR_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clk_div_in(clk_div_in), .en(en),
        .clr_err(clr_err), .tick(tick), .locked(locked), .fault(fault),
        .period(period), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Pulse counters sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (tick)  n_tick++;
        if (fault) n_fault++;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One divided-clock period: hi cycles high then lo cycles low; rise seen 2 edges in.
    task automatic gen_period(input int hi, input int lo);
        clk_div_in = 1'b1;
        step(hi);
        clk_div_in = 1'b0;
        step(lo);
    endtask

    initial begin
        rst_n = 1'b0; clk_div_in = 1'b0; en = 1'b0; clr_err = 1'b0;
        step(3);
        chk("rst_tick", tick, 0);
        chk("rst_locked", locked, 0);
        chk("rst_period", period, 0);
        chk("rst_err_cnt", err_cnt, 0);
        rst_n = 1'b1;
        step(2);

        // 1: nominal period 8, lock on the 5th tick
        en = 1'b1;
        repeat (4) gen_period(4, 4);
        chk("t1_ticks4", n_tick, 4);
        chk("t1_unlocked_after4", locked, 0);
        gen_period(4, 4);
        chk("t1_ticks5", n_tick, 5);
        chk("t1_locked_after5", locked, 1);
        chk("t1_period", period, 8);
        chk("t1_faults", n_fault, 0);
        chk("t1_err_cnt", err_cnt, 0);

        // 2: period 10; the first gap is still 8
        gen_period(5, 5);
        chk("t2_first_ok_err", err_cnt, 0);
        chk("t2_first_ok_locked", locked, 1);
        gen_period(5, 5);
        chk("t2_err1", err_cnt, 1);
        chk("t2_unlocked", locked, 0);
        repeat (2) gen_period(5, 5);
        chk("t2_err3", err_cnt, 3);
        chk("t2_faults3", n_fault, 3);
        chk("t2_period", period, 10);
        chk("t2_still_unlocked", locked, 0);

        // 3: relock (first gap 10 errors), then missing edge
        repeat (5) gen_period(4, 4);
        chk("t3_err4", err_cnt, 4);
        chk("t3_locked", locked, 1);
        step(10);
        chk("t3_timeout_err", err_cnt, 5);
        chk("t3_timeout_fault", n_fault, 5);
        chk("t3_timeout_unlocked", locked, 0);
        step(20);
        chk("t3_counted_once", err_cnt, 5);
        repeat (4) gen_period(4, 4);
        chk("t3_late_edge_unchecked", err_cnt, 5);
        chk("t3_not_yet_locked", locked, 0);
        gen_period(4, 4);
        chk("t3_relocked", locked, 1);

        // 4: jitter 7/9 inside tolerance, then a single 6
        repeat (3) begin
            gen_period(4, 3);
            gen_period(4, 5);
        end
        chk("t4_jitter_locked", locked, 1);
        chk("t4_jitter_faults", n_fault, 5);
        gen_period(3, 3);
        gen_period(4, 4);
        chk("t4_short_err", err_cnt, 6);
        chk("t4_short_unlocked", locked, 0);
        chk("t4_short_period", period, 6);

        // 5: relock, async reset mid-lock, saturation, clear priority
        repeat (5) gen_period(4, 4);
        chk("t5_locked", locked, 1);
        chk("t5_err_cnt", err_cnt, 6);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_async_locked", locked, 0);
        chk("t5_async_period", period, 0);
        chk("t5_async_err_cnt", err_cnt, 0);
        chk("t5_async_tick", tick, 0);
        chk("t5_async_fault", fault, 0);
        step(2);
        rst_n = 1'b1;
        snap_fault = n_fault;
        repeat (300) gen_period(2, 2);
        chk("t5_sat_faults", n_fault - snap_fault, 299);
        chk("t5_saturated", err_cnt, 255);
        clk_div_in = 1'b1;
        step(2);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        chk("t5_clr_wins_cnt", err_cnt, 0);
        chk("t5_clr_fault", fault, 1);
        clk_div_in = 1'b0;
        step(2);

        // 6: enable gating
        repeat (5) gen_period(4, 4);
        chk("t6_locked", locked, 1);
        chk("t6_err_cnt", err_cnt, 1);
        en = 1'b0;
        step(1);
        chk("t6_disable_unlocked", locked, 0);
        snap_tick  = n_tick;
        snap_fault = n_fault;
        repeat (3) gen_period(4, 4);
        gen_period(3, 3);
        chk("t6_no_ticks", n_tick - snap_tick, 0);
        chk("t6_no_faults", n_fault - snap_fault, 0);
        chk("t6_period_held", period, 8);
        chk("t6_err_held", err_cnt, 1);
        en = 1'b1;
        repeat (4) gen_period(4, 4);
        chk("t6_not_yet_locked", locked, 0);
        gen_period(4, 4);
        chk("t6_relocked", locked, 1);
        chk("t6_relock_err", err_cnt, 1);
        chk("t6_relock_period", period, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
